// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: raw button inputs, clear and scanned display outputs of seg_scan_ctrl
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  logic              btn_run;
  logic              btn_cnt;
  logic              btn_mode;
  logic              clr;
  logic [DIGITS-1:0] led_en;
  logic [7:0]        led_cx;
  modport master (output btn_run, btn_cnt, btn_mode, clr, input led_en, led_cx);
  modport slave (input btn_run, btn_cnt, btn_mode, clr, output led_en, led_cx);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: debounced stopwatch + event counter on a time-multiplexed N-digit 7-segment display
// Define LEAD_ZERO_BLANK_EN to blank digits above the most significant nonzero digit.
module seg_scan_ctrl #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DIGITS      = 8,
  parameter int SCAN_HZ     = 1000,
  parameter int TICK_HZ     = 10,
  parameter int DEBOUNCE_MS = 20
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int SCAN_CYC = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int SW = $clog2(SCAN_CYC + 1);
  localparam int TW = $clog2(TICK_CYC + 1);
  localparam int DW = $clog2(DB_CYC + 1);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = 4 * DIGITS;
  localparam logic [SW-1:0] SCAN_END = SW'(SCAN_CYC - 1);
  localparam logic [TW-1:0] TICK_END = TW'(TICK_CYC - 1);
  localparam logic [DW-1:0] DB_END   = DW'(DB_CYC - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(DIGITS - 1);
  localparam logic [IW-1:0] IDX_DP   = IW'(1);

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic c;
    c = 1'b1;
    bcd_inc = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        bcd_inc[4*i +: 4] = v[4*i +: 4] == 4'd9 ? 4'd0 : v[4*i +: 4] + 4'd1;
        c = v[4*i +: 4] == 4'd9;
      end
    end
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // bit 0 = run, bit 1 = cnt, bit 2 = mode
  logic [2:0]          s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d, pls_q, pls_d;
  logic [2:0][DW-1:0]  dbc_q, dbc_d;
  logic                run_q, run_d, mode_q, mode_d, tick;
  logic [TW-1:0]       pre_q, pre_d;
  logic [BW-1:0]       tmr_q, tmr_d, cnt_q, cnt_d, val, sh;
  logic [SW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   led_en_q, led_en_d;
  logic [7:0]          led_cx_q, led_cx_d, cx;

  always_comb begin
    s1_d = {bus.btn_mode, bus.btn_cnt, bus.btn_run};
    s2_d = s1_q;
    for (int i = 0; i < 3; i++) begin
      dbc_d[i] = s2_q[i] != lvl_q[i] && dbc_q[i] != DB_END ? dbc_q[i] + 1'b1 : '0;
      lvl_d[i] = s2_q[i] != lvl_q[i] && dbc_q[i] == DB_END ? s2_q[i] : lvl_q[i];
      pls_d[i] = s2_q[i] && !lvl_q[i] && dbc_q[i] == DB_END;
    end
    tick = run_q && pre_q == TICK_END;
    run_d = run_q ^ pls_q[0];
    mode_d = mode_q ^ pls_q[2];
    pre_d = bus.clr || tick ? '0 : run_q ? pre_q + 1'b1 : pre_q;
    tmr_d = bus.clr ? '0 : tick ? bcd_inc(tmr_q) : tmr_q;
    cnt_d = bus.clr ? '0 : pls_q[1] ? bcd_inc(cnt_q) : cnt_q;
    div_d = div_q == SCAN_END ? '0 : div_q + 1'b1;
    idx_d = div_q != SCAN_END ? idx_q : idx_q == IDX_END ? '0 : idx_q + 1'b1;
    val = mode_q ? cnt_q : tmr_q;
    sh = val >> {idx_q, 2'b00};
    cx = {mode_q || idx_q != IDX_DP, seg7(sh[3:0])};
`ifdef LEAD_ZERO_BLANK_EN
    led_cx_d = sh == '0 && idx_q != '0 && (mode_q || idx_q != IDX_DP) ? 8'hFF : cx;
`else
    led_cx_d = cx;
`endif
    led_en_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      lvl_q    <= '0;
      pls_q    <= '0;
      dbc_q    <= '0;
      run_q    <= 1'b0;
      mode_q   <= 1'b0;
      pre_q    <= '0;
      tmr_q    <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      led_en_q <= '1;
      led_cx_q <= 8'hFF;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      lvl_q    <= lvl_d;
      pls_q    <= pls_d;
      dbc_q    <= dbc_d;
      run_q    <= run_d;
      mode_q   <= mode_d;
      pre_q    <= pre_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      led_en_q <= led_en_d;
      led_cx_q <= led_cx_d;
    end
  end

  assign bus.led_en = led_en_q;
  assign bus.led_cx = led_cx_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: checks 8-digit and 2-digit instances against a decimal display model
module tb_seg_scan_ctrl;
  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic clk, rst, btn_run, btn_cnt, btn_mode, clr;
  int n_chk, n_fail, cnt_v, tmr_v;
  bit mode_v;
  logic [7:0] cx8 [8];
  logic [7:0] cx2 [2];

  seg_scan_ctrl_if #(.DIGITS(8)) b8 ();
  seg_scan_ctrl_if #(.DIGITS(2)) b2 ();
  assign b8.btn_run = btn_run;
  assign b8.btn_cnt = btn_cnt;
  assign b8.btn_mode = btn_mode;
  assign b8.clr = clr;
  assign b2.btn_run = btn_run;
  assign b2.btn_cnt = btn_cnt;
  assign b2.btn_mode = btn_mode;
  assign b2.clr = clr;

  seg_scan_ctrl #(.CLK_HZ(8000), .DIGITS(8), .SCAN_HZ(125), .TICK_HZ(10), .DEBOUNCE_MS(1))
    dut8 (.clk(clk), .rst(rst), .bus(b8));
  seg_scan_ctrl #(.CLK_HZ(8000), .DIGITS(2), .SCAN_HZ(125), .TICK_HZ(10), .DEBOUNCE_MS(1))
    dut2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p *= 10;
    return p;
  endfunction

  function automatic logic [7:0] exp_cx(input int val, input int k, input bit mode);
    int p = pow10(k);
    logic [7:0] c = SEG[(val / p) % 10];
    if (!mode && k == 1) c[7] = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    if (k > 0 && !(!mode && k == 1) && val / p == 0) c = 8'hFF;
`endif
    return c;
  endfunction

  task automatic press(input int which);
    if (which == 0) btn_run = 1'b1;
    else if (which == 1) btn_cnt = 1'b1;
    else btn_mode = 1'b1;
    cyc(20);
    btn_run = 1'b0;
    btn_cnt = 1'b0;
    btn_mode = 1'b0;
    cyc(20);
    if (which == 1) cnt_v = (cnt_v + 1) % 100000000;
    if (which == 2) mode_v = ~mode_v;
  endtask

  task automatic glitch(input int which, input int len);
    if (which == 0) btn_run = 1'b1;
    else if (which == 1) btn_cnt = 1'b1;
    else btn_mode = 1'b1;
    cyc(len);
    btn_run = 1'b0;
    btn_cnt = 1'b0;
    btn_mode = 1'b0;
    cyc(12);
  endtask

  task automatic check_frame(input string tag);
    logic [9:0] seen = '0;
    int v8 = mode_v ? cnt_v : tmr_v;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++)
        if (b8.led_en === ~(8'd1 << k)) begin cx8[k] = b8.led_cx; seen[k] = 1'b1; end
      for (int k = 0; k < 2; k++)
        if (b2.led_en === ~(2'd1 << k)) begin cx2[k] = b2.led_cx; seen[8+k] = 1'b1; end
    end
    chk($sformatf("%s_scan", tag), 32'(seen), 32'h3FF);
    for (int k = 0; k < 8; k++) chk($sformatf("%s_d8_%0d", tag, k), 32'(cx8[k]), 32'(exp_cx(v8, k, mode_v)));
    for (int k = 0; k < 2; k++) chk($sformatf("%s_d2_%0d", tag, k), 32'(cx2[k]), 32'(exp_cx(v8 % 100, k, mode_v)));
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cnt_v = 0; tmr_v = 0; mode_v = 1'b0;
    rst = 1'b0; btn_run = 1'b0; btn_cnt = 1'b0; btn_mode = 1'b0; clr = 1'b0;
    cyc(3);
    chk("rst_en8", 32'(b8.led_en), 32'hFF);
    chk("rst_cx8", 32'(b8.led_cx), 32'hFF);
    chk("rst_en2", 32'(b2.led_en), 32'h3);
    chk("rst_cx2", 32'(b2.led_cx), 32'hFF);
    rst = 1'b1;
    cyc(1);
    chk("first_en8", 32'(b8.led_en), 32'hFE);
    chk("first_cx8", 32'(b8.led_cx), 32'hC0);
    chk("first_en2", 32'(b2.led_en), 32'h2);
    chk("first_cx2", 32'(b2.led_cx), 32'hC0);
    cyc(3);
    for (int j = 0; j < 17; j++) begin
      chk($sformatf("scan_en_%0d", j), 32'(b8.led_en), 32'(8'(~(8'd1 << (j % 8)))));
      if (j % 8 == 1) chk($sformatf("scan_dp_%0d", j), 32'(b8.led_cx), 32'h40);
      cyc(8);
    end
    check_frame("idle");
    glitch(1, 3);
    cyc(20);
    check_frame("glitch3");
    btn_cnt = 1'b1;
    cyc(1000);
    btn_cnt = 1'b0;
    cyc(20);
    cnt_v = 1;
    check_frame("hold1000");
    press(1);
    check_frame("press2");
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0, 1: press(1);
        2: glitch($urandom_range(0, 2), $urandom_range(1, 5));
        3: press(2);
        default: repeat ($urandom_range(1, 4)) press(1);
      endcase
      check_frame($sformatf("rnd%0d", i));
    end
    if (!mode_v) press(2);
    while (cnt_v % 100 != 99) press(1);
    check_frame("wrap99");
    press(1);
    check_frame("wrap00");
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cnt_v = 0;
    tmr_v = 0;
    if (mode_v) press(2);
    check_frame("sw0");
    press(0);
    cyc(8360);
    tmr_v = 10;
    check_frame("sw10");
    press(0);
    cyc(2000);
    check_frame("sw_frozen");
    press(0);
    cyc(650);
    tmr_v = 11;
    check_frame("sw_phase");
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    tmr_v = 0;
    cnt_v = 0;
    cyc(300);
    check_frame("clr0");
    cyc(500);
    tmr_v = 1;
    check_frame("clr_run");
    press(0);
    press(2);
    check_frame("mode_cnt0");
    repeat (3) press(1);
    check_frame("mode_cnt3");
    press(2);
    check_frame("mode_tmr");
    press(2);
    repeat (302) press(1);
    check_frame("cnt305");
    press(0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_en8", 32'(b8.led_en), 32'hFF);
    chk("mid_rst_cx8", 32'(b8.led_cx), 32'hFF);
    chk("mid_rst_en2", 32'(b2.led_en), 32'h3);
    chk("mid_rst_cx2", 32'(b2.led_cx), 32'hFF);
    cyc(2);
    rst = 1'b1;
    cnt_v = 0;
    tmr_v = 0;
    mode_v = 1'b0;
    check_frame("post_rst");
    cyc(1000);
    check_frame("post_rst_stopped");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
